shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameters: none; data width fixed at 32, shift amount fixed at 5 bits.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req0_valid / req1_valid  in  1 each  requester n has a shift request pending.
REQ-006 req0_ready / req1_ready  out  1 each  request n accepted this cycle when valid&ready.
REQ-007 req0_op / req1_op  in  2 each  00 SLL, 01 SRL, 10 reserved, 11 SRA.
REQ-008 req0_amt / req1_amt  in  5 each  shift amount 0..31.
REQ-009 req0_data / req1_data  in  32 each  operand to shift.
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  consumer takes result when rsp_valid&rsp_ready.
REQ-012 rsp_id  out  1  requester index owning the result.
REQ-013 rsp_data  out  32  shifted result.
REQ-014 rsp_err  out  1  result came from reserved op 10.

Function
REQ-015 The block SHALL share one combinational shifter between two requesters through a two-stage pipeline: issue register (op, amt, data, id), then result register (data, id, err).
REQ-016 Arbitration SHALL be round-robin: a lone valid requester is granted; when both are valid, the requester not granted last is granted; the last-grant bit SHALL update only on an accepted request.
REQ-017 reqN_ready SHALL be high only for the granted requester, and only when the issue register is empty or advancing this cycle; the ungranted ready SHALL be 0.
REQ-018 Requesters SHALL NOT wait for ready before asserting valid; ready may depend combinationally on valid.
REQ-019 Latency: a request accepted at edge N SHALL present rsp_valid in the cycle after edge N+1 (2 cycles) when there is no backpressure.
REQ-020 Throughput SHALL be one request per cycle while rsp_ready is held high.
REQ-021 The issue register SHALL advance into the result register when the result register is empty or is being consumed this cycle; otherwise both stages hold.
REQ-022 rsp_valid, rsp_id, rsp_data and rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-023 Shifts: SLL fills with zeros; SRL fills with zeros; SRA fills with operand bit 31; amt 0 returns the operand unchanged.
REQ-024 Op 10 SHALL produce rsp_data=0 and rsp_err=1; all other ops produce rsp_err=0.
REQ-025 Accepted requests SHALL never be dropped or reordered; responses return in acceptance order.
REQ-026 When the pipeline is full and rsp_ready=0, both ready outputs SHALL be 0.

Reset
REQ-027 While rst=1: issue and result valid flags clear, last-grant bit set to 1 (requester 0 wins the first tie).
REQ-028 Outputs during and after reset: req0_ready=req1_ready=0 during reset; rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
REQ-029 Reset mid-operation SHALL discard all in-flight requests without producing a response.

Structure
REQ-030 The shared package SHALL hold the op encoding constants (SLL, SRL, reserved, SRA) and the data/amount width constants.
REQ-031 The shifter SHALL be a separate combinational sub-module, shift_core (inputs op, amt, data; output result), instantiated once.
REQ-032 Arbiter, issue register and result register SHALL reside in shift_arbiter.

Verification
REQ-033 req0: SLL, data 0x00000001, amt 31, rsp_ready=1 -> two cycles later rsp_valid=1, rsp_id=0, rsp_data=0x80000000, rsp_err=0.
REQ-034 req1: SRA then SRL, data 0x80000000, amt 4 -> first response 0xF8000000, then 0x08000000, both with rsp_id=1, in order.
REQ-035 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; rsp_id sequence is 0,1,0,1 at one per cycle.
REQ-036 rsp_ready=0 for 5 cycles with both requesters valid -> exactly two requests are accepted, then both ready outputs are 0 and rsp outputs stay stable; on release, responses drain in order with none lost.
REQ-037 Op 10, data 0xFFFFFFFF -> rsp_data=0x00000000, rsp_err=1.
REQ-038 rst asserted one cycle after an acceptance -> no response after rst deasserts, and the first tie is granted to requester 0.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the two-requester shift arbiter: widths, requester count
// and the shift operation encoding.
package shift_arbiter_pkg;
    localparam int DATA_W  = 32;
    localparam int AMT_W   = 5;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_RSV = 2'b10,
        OP_SRA = 2'b11
    } shift_op_e;

    function automatic logic op_is_reserved(input shift_op_e op);
        return op == OP_RSV;
    endfunction
endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle of the shift arbiter; master drives requests and
// consumes responses, slave is the arbiter itself.
interface shift_arbiter_if;
    import shift_arbiter_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [1:0]        req0_op;
    logic [AMT_W-1:0]  req0_amt;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [1:0]        req1_op;
    logic [AMT_W-1:0]  req1_amt;
    logic [DATA_W-1:0] req1_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_op, req0_amt, req0_data,
        output req1_valid, req1_op, req1_amt, req1_data,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_amt, req0_data,
        input  req1_valid, req1_op, req1_amt, req1_data,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/shift_arbiter_core.sv
// Purely combinational 32-bit shifter shared by both requesters.
module shift_core
    import shift_arbiter_pkg::*;
(
    input  shift_op_e         op,
    input  logic [AMT_W-1:0]  amt,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] result
);
    always_comb begin
        result = '0;
        unique case (op)
            OP_SLL:  result = data << amt;
            OP_SRL:  result = data >> amt;
            OP_SRA:  result = DATA_W'($signed(data) >>> amt);
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding one shared shifter through an issue register and
// a result register, with full backpressure from the response side.
module shift_arbiter
    import shift_arbiter_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    shift_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0] valid_vec;
    logic [NUM_REQ-1:0] ready_vec;
    logic [1:0]         op_vec   [NUM_REQ];
    logic [AMT_W-1:0]   amt_vec  [NUM_REQ];
    logic [DATA_W-1:0]  data_vec [NUM_REQ];

    logic              last_grant_reg;
    logic              issue_valid_reg;
    shift_op_e         issue_op_reg;
    logic [AMT_W-1:0]  issue_amt_reg;
    logic [DATA_W-1:0] issue_data_reg;
    logic              issue_id_reg;
    logic              rsp_valid_reg;
    logic              rsp_id_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              rsp_err_reg;

    logic              grant_id;
    logic              res_advance;
    logic              issue_free;
    logic              accept;
    logic [DATA_W-1:0] core_result;

    assign valid_vec   = {bus.req1_valid, bus.req0_valid};
    assign op_vec[0]   = bus.req0_op;
    assign op_vec[1]   = bus.req1_op;
    assign amt_vec[0]  = bus.req0_amt;
    assign amt_vec[1]  = bus.req1_amt;
    assign data_vec[0] = bus.req0_data;
    assign data_vec[1] = bus.req1_data;

    // On a tie the requester that did not win last time goes first.
    assign grant_id    = (valid_vec == 2'b11) ? ~last_grant_reg : valid_vec[1];
    assign res_advance = !rsp_valid_reg || bus.rsp_ready;
    assign issue_free  = !issue_valid_reg || res_advance;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign ready_vec[gi] = !rst && issue_free && valid_vec[gi]
                                   && (grant_id == (gi == 1));
        end
    endgenerate

    assign accept         = |(valid_vec & ready_vec);
    assign bus.req0_ready = ready_vec[0];
    assign bus.req1_ready = ready_vec[1];

    shift_core u_core (
        .op     (issue_op_reg),
        .amt    (issue_amt_reg),
        .data   (issue_data_reg),
        .result (core_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg  <= 1'b1;
            issue_valid_reg <= 1'b0;
            issue_op_reg    <= OP_SLL;
            issue_amt_reg   <= '0;
            issue_data_reg  <= '0;
            issue_id_reg    <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_id_reg      <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_err_reg     <= 1'b0;
        end else begin
            if (accept) begin
                issue_valid_reg <= 1'b1;
                issue_op_reg    <= shift_op_e'(op_vec[grant_id]);
                issue_amt_reg   <= amt_vec[grant_id];
                issue_data_reg  <= data_vec[grant_id];
                issue_id_reg    <= grant_id;
                last_grant_reg  <= grant_id;
            end else if (res_advance) begin
                issue_valid_reg <= 1'b0;
            end
            // Result payload only reloads when a real entry moves up, so a stalled
            // or drained response keeps its last value.
            if (res_advance) begin
                rsp_valid_reg <= issue_valid_reg;
                if (issue_valid_reg) begin
                    rsp_id_reg   <= issue_id_reg;
                    rsp_data_reg <= core_result;
                    rsp_err_reg  <= op_is_reserved(issue_op_reg);
                end
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    shift_arbiter_if bus();

    shift_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
        bit          vis;
    } ent_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } obs_t;

    typedef struct {
        logic id;
        int   cyc;
    } acc_t;

    ent_t mq[$];
    obs_t obs_q[$];
    acc_t acc_q[$];
    bit   m_last  = 1'b1;
    bit   m_clean = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic e_grant, e_free, e_rdy0, e_rdy1, e_vld;
    ent_t new_ent;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Reference shift from plain arithmetic on the operand.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] amt,
                                              input logic [31:0] d);
        logic [63:0] ext;
        case (op)
            2'b00:   return 32'((64'(d) * (64'd1 << amt)));
            2'b01:   return 32'(d / (32'd1 << amt));
            2'b11: begin
                ext = {{32{d[31]}}, d};
                ext = ext >> amt;
                return ext[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle compare against the model, response/accept monitor, model step.
    initial forever begin
        @(negedge clk);
        e_grant = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
        e_free  = (mq.size() < 2) || bus.rsp_ready;
        e_rdy0  = !rst && e_free && bus.req0_valid && !e_grant;
        e_rdy1  = !rst && e_free && bus.req1_valid && e_grant;
        e_vld   = (mq.size() > 0) && mq[0].vis;
        check("req0_ready", 32'(bus.req0_ready), 32'(e_rdy0));
        check("req1_ready", 32'(bus.req1_ready), 32'(e_rdy1));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(e_vld));
        if (e_vld) begin
            check("rsp_id", 32'(bus.rsp_id), 32'(mq[0].id));
            check("rsp_data", bus.rsp_data, mq[0].data);
            check("rsp_err", 32'(bus.rsp_err), 32'(mq[0].err));
        end else if (m_clean) begin
            check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
            check("rst_rsp_data", bus.rsp_data, 32'h0);
            check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        end

        if (!rst && bus.rsp_valid && bus.rsp_ready)
            obs_q.push_back('{id: bus.rsp_id, data: bus.rsp_data, err: bus.rsp_err, cyc: cyc});
        if (bus.req0_valid && bus.req0_ready) acc_q.push_back('{id: 1'b0, cyc: cyc});
        if (bus.req1_valid && bus.req1_ready) acc_q.push_back('{id: 1'b1, cyc: cyc});

        if (rst) begin
            mq.delete();
            m_last  = 1'b1;
            m_clean = 1'b1;
        end else begin
            if (e_vld && bus.rsp_ready) void'(mq.pop_front());
            if (mq.size() > 0 && !mq[0].vis) begin
                mq[0].vis = 1'b1;
                m_clean   = 1'b0;
            end
            if (e_rdy0 || e_rdy1) begin
                new_ent.id   = e_grant;
                new_ent.data = e_grant ? ref_shift(bus.req1_op, bus.req1_amt, bus.req1_data)
                                       : ref_shift(bus.req0_op, bus.req0_amt, bus.req0_data);
                new_ent.err  = e_grant ? (bus.req1_op == 2'b10) : (bus.req0_op == 2'b10);
                new_ent.vis  = 1'b0;
                mq.push_back(new_ent);
                m_last = e_grant;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [4:0] amt, input logic [31:0] d);
        if (i == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_amt = amt; bus.req0_data = d;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_amt = amt; bus.req1_data = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    int ob, ab;
    logic [1:0] rop;
    logic [4:0] ramt;

    initial begin
        set_req(0, 0, 2'b00, 5'd0, 32'h0);
        set_req(1, 0, 2'b00, 5'd0, 32'h0);
        bus.rsp_ready = 1'b1;
        tick(3);
        rst = 1'b0;

        // SLL of 1 by 31 from requester 0, two-cycle latency
        ob = obs_q.size(); ab = acc_q.size();
        set_req(0, 1, 2'b00, 5'd31, 32'h0000_0001);
        tick(1);
        set_req(0, 0, 2'b00, 5'd0, 32'h0);
        tick(4);
        check("sll31_count", 32'(obs_q.size() - ob), 32'd1);
        if (obs_q.size() > ob && acc_q.size() > ab) begin
            check("sll31_id", 32'(obs_q[ob].id), 32'd0);
            check("sll31_data", obs_q[ob].data, 32'h8000_0000);
            check("sll31_err", 32'(obs_q[ob].err), 32'd0);
            check("sll31_latency", 32'(obs_q[ob].cyc - acc_q[ab].cyc), 32'd2);
        end

        // SRA then SRL from requester 1, in order
        ob = obs_q.size();
        set_req(1, 1, 2'b11, 5'd4, 32'h8000_0000);
        tick(1);
        set_req(1, 1, 2'b01, 5'd4, 32'h8000_0000);
        tick(1);
        set_req(1, 0, 2'b00, 5'd0, 32'h0);
        tick(4);
        check("sra_srl_count", 32'(obs_q.size() - ob), 32'd2);
        if (obs_q.size() >= ob + 2) begin
            check("sra_data", obs_q[ob].data, 32'hF800_0000);
            check("sra_id", 32'(obs_q[ob].id), 32'd1);
            check("srl_data", obs_q[ob+1].data, 32'h0800_0000);
            check("srl_id", 32'(obs_q[ob+1].id), 32'd1);
        end

        // Reserved op
        ob = obs_q.size();
        set_req(0, 1, 2'b10, 5'd7, 32'hFFFF_FFFF);
        tick(1);
        set_req(0, 0, 2'b00, 5'd0, 32'h0);
        tick(4);
        check("rsv_count", 32'(obs_q.size() - ob), 32'd1);
        if (obs_q.size() > ob) begin
            check("rsv_data", obs_q[ob].data, 32'h0);
            check("rsv_err", 32'(obs_q[ob].err), 32'd1);
        end

        // Both requesters continuously valid: alternating grants, one per cycle
        do_reset();
        ob = obs_q.size(); ab = acc_q.size();
        set_req(0, 1, 2'b00, 5'd1, 32'h0000_0003);
        set_req(1, 1, 2'b01, 5'd1, 32'h0000_0030);
        tick(8);
        set_req(0, 0, 2'b00, 5'd0, 32'h0);
        set_req(1, 0, 2'b00, 5'd0, 32'h0);
        tick(4);
        check("rr_acc_count", 32'(acc_q.size() - ab), 32'd8);
        check("rr_rsp_count", 32'(obs_q.size() - ob), 32'd8);
        if (acc_q.size() >= ab + 4 && obs_q.size() >= ob + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("rr_grant", 32'(acc_q[ab+k].id), 32'(k % 2));
                check("rr_rsp_id", 32'(obs_q[ob+k].id), 32'(k % 2));
            end
            check("rr_rate", 32'(obs_q[ob+3].cyc - obs_q[ob].cyc), 32'd3);
        end

        // Stall with both valid: exactly two accepted, then all ready low
        do_reset();
        ob = obs_q.size(); ab = acc_q.size();
        bus.rsp_ready = 1'b0;
        set_req(0, 1, 2'b00, 5'd4, 32'h0000_0011);
        set_req(1, 1, 2'b11, 5'd8, 32'hF000_0000);
        tick(5);
        check("stall_acc_count", 32'(acc_q.size() - ab), 32'd2);
        check("stall_req0_ready", 32'(bus.req0_ready), 32'd0);
        check("stall_req1_ready", 32'(bus.req1_ready), 32'd0);
        check("stall_rsp_data", bus.rsp_data, 32'h0000_0110);
        bus.rsp_ready = 1'b1;
        set_req(0, 0, 2'b00, 5'd0, 32'h0);
        set_req(1, 0, 2'b00, 5'd0, 32'h0);
        tick(4);
        check("stall_rsp_count", 32'(obs_q.size() - ob), 32'd2);
        if (obs_q.size() >= ob + 2) begin
            check("stall_rsp0_id", 32'(obs_q[ob].id), 32'd0);
            check("stall_rsp1_id", 32'(obs_q[ob+1].id), 32'd1);
            check("stall_rsp1_data", obs_q[ob+1].data, 32'hFFF0_0000);
        end

        // Reset one cycle after an acceptance discards it; first tie goes to 0
        do_reset();
        ob = obs_q.size(); ab = acc_q.size();
        set_req(1, 1, 2'b00, 5'd2, 32'h0000_0005);
        tick(1);
        set_req(1, 0, 2'b00, 5'd0, 32'h0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        check("rst_drop_acc", 32'(acc_q.size() - ab), 32'd1);
        check("rst_drop_rsp", 32'(obs_q.size() - ob), 32'd0);
        ab = acc_q.size();
        set_req(0, 1, 2'b00, 5'd0, 32'h0000_00AA);
        set_req(1, 1, 2'b00, 5'd0, 32'h0000_00BB);
        tick(1);
        set_req(0, 0, 2'b00, 5'd0, 32'h0);
        set_req(1, 0, 2'b00, 5'd0, 32'h0);
        check("rst_first_tie_count", 32'(acc_q.size() - ab), 32'd1);
        if (acc_q.size() > ab) check("rst_first_tie_id", 32'(acc_q[ab].id), 32'd0);
        tick(4);

        // Randomized traffic with occasional resets and backpressure
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < 2; i++) begin
                rop  = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       ramt = 5'd0;
                    1:       ramt = 5'd31;
                    default: ramt = 5'($urandom_range(0, 31));
                endcase
                set_req(i, ($urandom_range(0, 9) < 6), rop, ramt, $urandom());
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            tick(1);
        end
        rst = 1'b0;
        set_req(0, 0, 2'b00, 5'd0, 32'h0);
        set_req(1, 0, 2'b00, 5'd0, 32'h0);
        bus.rsp_ready = 1'b1;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
